// File: rtl/render_pkg.sv
// Shared types and widths for the frame scheduler and its edit FIFO.
package render_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_START  = 2'd2,
        S_RENDER = 2'd3
    } state_t;

    localparam int POS_W   = 17;
    localparam int ANG_W   = 20;
    localparam int BADDR_W = 15;
    localparam int BID_W   = 5;
    localparam int PIX_W   = 20;
    localparam int EDIT_W  = BADDR_W + BID_W;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/render_sched_edit_fifo.sv
// Synchronous FIFO holding block edits until the scheduler is idle.
module edit_fifo
    import render_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/render_sched.sv
// Frame scheduler: latches pose, starts ppl, tracks pixels and watchdog,
// and applies buffered map edits only between frames.
module render_sched
    import render_pkg::*;
#(
    parameter int H_DISP     = 480,
    parameter int V_DISP     = 272,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 2000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_req,
    input  logic [POS_W-1:0]   in_pos_x,
    input  logic [POS_W-1:0]   in_pos_y,
    input  logic [POS_W-1:0]   in_pos_z,
    input  logic [ANG_W-1:0]   in_angle_x,
    input  logic [ANG_W-1:0]   in_angle_y,
    input  logic               ppl_valid,
    input  logic               edit_valid,
    input  logic [BADDR_W-1:0] edit_addr,
    input  logic [BID_W-1:0]   edit_data,
    output logic               edit_ready,
    output logic [POS_W-1:0]   p_pos_x,
    output logic [POS_W-1:0]   p_pos_y,
    output logic [POS_W-1:0]   p_pos_z,
    output logic [ANG_W-1:0]   p_angle_x,
    output logic [ANG_W-1:0]   p_angle_y,
    output logic               ppl_start,
    output logic               write_en,
    output logic [BADDR_W-1:0] write_addr,
    output logic [BID_W-1:0]   write_data,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
    output logic               timeout_err
);

    localparam int WD_W = clog2(TIMEOUT + 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(H_DISP * V_DISP - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    state_t             state;
    logic [PIX_W-1:0]   pix_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic [EDIT_W-1:0]  fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    // A frame request in IDLE takes priority over draining the edit queue.
    assign fifo_pop   = (state == S_IDLE) && !frame_req && !fifo_empty;
    assign edit_ready = !fifo_full;

    edit_fifo #(.WIDTH(EDIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (edit_valid),
        .wdata ({edit_addr, edit_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pix_cnt     <= '0;
            wd_cnt      <= '0;
            p_pos_x     <= '0;
            p_pos_y     <= '0;
            p_pos_z     <= '0;
            p_angle_x   <= '0;
            p_angle_y   <= '0;
            ppl_start   <= 1'b0;
            write_en    <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ppl_start  <= 1'b0;
            frame_done <= 1'b0;
            write_en   <= 1'b0;
            overrun    <= frame_req && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (frame_req) begin
                        state       <= S_LATCH;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end else if (!fifo_empty) begin
                        write_en   <= 1'b1;
                        write_addr <= fifo_rdata[EDIT_W-1:BID_W];
                        write_data <= fifo_rdata[BID_W-1:0];
                    end
                end
                S_LATCH: begin
                    p_pos_x   <= in_pos_x;
                    p_pos_y   <= in_pos_y;
                    p_pos_z   <= in_pos_z;
                    p_angle_x <= in_angle_x;
                    p_angle_y <= in_angle_y;
                    ppl_start <= 1'b1;
                    state     <= S_START;
                end
                S_START: begin
                    pix_cnt <= '0;
                    wd_cnt  <= '0;
                    state   <= S_RENDER;
                end
                S_RENDER: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (ppl_valid) pix_cnt <= pix_cnt + PIX_W'(1);
                    // Completing the last pixel beats a watchdog expiring in the same cycle.
                    if (ppl_valid && pix_cnt == PIX_LAST) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_render_sched.sv
// Directed bench for render_sched with a cycle-level reference model.
module tb_render_sched;

    localparam int H = 32, V = 24, NPIX = H * V, DEPTH = 8;
    localparam int TO_MAIN = 1000, TO_WD = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        frame_req = 0, ppl_valid = 0, edit_valid = 0;
    logic [16:0] in_pos_x = 0, in_pos_y = 0, in_pos_z = 0;
    logic [19:0] in_angle_x = 0, in_angle_y = 0;
    logic [14:0] edit_addr = 0;
    logic [4:0]  edit_data = 0;
    logic        edit_ready, ppl_start, write_en, busy, frame_done, overrun, timeout_err;
    logic [16:0] p_pos_x, p_pos_y, p_pos_z;
    logic [19:0] p_angle_x, p_angle_y;
    logic [14:0] write_addr;
    logic [4:0]  write_data;

    // Second instance with a short watchdog, driven separately.
    logic        w_frame_req = 0, w_valid = 0, w_edit_valid = 0;
    logic [14:0] w_edit_addr = 0;
    logic [4:0]  w_edit_data = 0;
    logic        w_edit_ready, w_ppl_start, w_write_en, w_busy, w_frame_done, w_overrun, w_timeout_err;
    logic [16:0] w_p_pos_x, w_p_pos_y, w_p_pos_z;
    logic [19:0] w_p_angle_x, w_p_angle_y;
    logic [14:0] w_write_addr;
    logic [4:0]  w_write_data;

    render_sched #(.H_DISP(H), .V_DISP(V), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO_MAIN)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_req(frame_req),
        .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_pos_z(in_pos_z),
        .in_angle_x(in_angle_x), .in_angle_y(in_angle_y), .ppl_valid(ppl_valid),
        .edit_valid(edit_valid), .edit_addr(edit_addr), .edit_data(edit_data),
        .edit_ready(edit_ready), .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
        .p_angle_x(p_angle_x), .p_angle_y(p_angle_y), .ppl_start(ppl_start),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
    );

    render_sched #(.H_DISP(H), .V_DISP(V), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO_WD)) u_wd (
        .clk(clk), .rst_n(rst_n), .frame_req(w_frame_req),
        .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_pos_z(in_pos_z),
        .in_angle_x(in_angle_x), .in_angle_y(in_angle_y), .ppl_valid(w_valid),
        .edit_valid(w_edit_valid), .edit_addr(w_edit_addr), .edit_data(w_edit_data),
        .edit_ready(w_edit_ready), .p_pos_x(w_p_pos_x), .p_pos_y(w_p_pos_y), .p_pos_z(w_p_pos_z),
        .p_angle_x(w_p_angle_x), .p_angle_y(w_p_angle_y), .ppl_start(w_ppl_start),
        .write_en(w_write_en), .write_addr(w_write_addr), .write_data(w_write_data),
        .busy(w_busy), .frame_done(w_frame_done), .overrun(w_overrun), .timeout_err(w_timeout_err)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: frame age in cycles since acceptance, pixel and render-cycle
    // counts, and a queue of pending edits.
    logic        e_busy = 0, e_start = 0, e_done = 0, e_over = 0, e_terr = 0, e_ready = 1, e_wen = 0;
    logic [14:0] e_waddr = 0;
    logic [4:0]  e_wdata = 0;
    logic [16:0] e_px = 0, e_py = 0, e_pz = 0;
    logic [19:0] e_ax = 0, e_ay = 0;
    logic [19:0] q[$];
    logic [19:0] head;
    int          age = 0, pix = 0, rcyc = 0;
    logic        m_pop, m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_busy = 0; e_start = 0; e_done = 0; e_over = 0; e_terr = 0; e_ready = 1; e_wen = 0;
            e_waddr = 0; e_wdata = 0; e_px = 0; e_py = 0; e_pz = 0; e_ax = 0; e_ay = 0;
            q.delete(); age = 0; pix = 0; rcyc = 0;
        end else begin
            e_over  = frame_req && e_busy;
            e_start = 0; e_done = 0; e_wen = 0;
            m_pop  = !e_busy && !frame_req && (q.size() > 0);
            m_push = edit_valid && e_ready;
            if (m_pop) begin
                head = q.pop_front();
                e_wen = 1; e_waddr = head[19:5]; e_wdata = head[4:0];
            end
            if (m_push) q.push_back({edit_addr, edit_data});
            e_ready = (q.size() < DEPTH);
            if (!e_busy) begin
                if (frame_req) begin e_busy = 1; age = 1; e_terr = 0; end
            end else begin
                age++;
                if (age == 2) begin
                    e_px = in_pos_x; e_py = in_pos_y; e_pz = in_pos_z;
                    e_ax = in_angle_x; e_ay = in_angle_y; e_start = 1;
                end else if (age == 3) begin
                    pix = 0; rcyc = 0;
                end else begin
                    rcyc++;
                    if (ppl_valid) pix++;
                    if (pix == NPIX) begin e_done = 1; e_busy = 0; end
                    else if (rcyc == TO_MAIN) begin e_terr = 1; e_busy = 0; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ctl", 128'({busy, ppl_start, frame_done, overrun, timeout_err, edit_ready}),
                128'({e_busy, e_start, e_done, e_over, e_terr, e_ready}));
            chk("write", 128'({write_en, write_addr, write_data}), 128'({e_wen, e_waddr, e_wdata}));
            chk("pose", 128'({p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y}),
                128'({e_px, e_py, e_pz, e_ax, e_ay}));
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    int  nv, nwr, k;
    logic seen, found;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_ready", 128'(edit_ready), 128'(1));
        chk("rst_outs", 128'({busy, ppl_start, write_en, frame_done, overrun, timeout_err, p_pos_x}), 128'(0));
        rst_n = 1;
        tick();

        // Frame 1: pose latch and start latency
        in_pos_x = 17'h5500; in_angle_x = 20'd30; in_pos_y = 17'h0123; in_pos_z = 17'h0077; in_angle_y = 20'h400;
        frame_req = 1;
        tick();
        frame_req = 0;
        chk("start_lat1", 128'({ppl_start, busy}), 128'(2'b01));
        tick();
        chk("start_lat2", 128'(ppl_start), 128'(1));
        chk("p_pos_x", 128'(p_pos_x), 128'(17'h5500));
        chk("p_angle_x", 128'(p_angle_x), 128'(20'd30));
        tick();
        chk("start_pulse", 128'(ppl_start), 128'(0));

        seen = 0;
        for (int i = 0; i < NPIX; i++) begin
            ppl_valid  = 1;
            frame_req  = (i == 400);
            edit_valid = (i >= 300 && i < 303);
            edit_addr  = 15'(i - 299);
            edit_data  = 5'(i - 296);
            if (i == 100) in_pos_x = 17'h1234;
            tick();
            if (write_en) seen = 1;
            if (i == 200) chk("pose_hold", 128'(p_pos_x), 128'(17'h5500));
            if (i == 400) chk("overrun", 128'({overrun, ppl_start}), 128'(2'b10));
            if (i == 401) chk("overrun_end", 128'(overrun), 128'(0));
            if (i == NPIX - 2) chk("not_done_early", 128'(frame_done), 128'(0));
        end
        chk("done_after_last", 128'({frame_done, busy}), 128'(2'b10));
        chk("no_write_in_frame", 128'(seen), 128'(0));

        // Drain three edits in order; stray valids in IDLE are ignored
        tick();
        chk("wr1", 128'({write_en, write_addr, write_data}), 128'({1'b1, 15'd1, 5'd4}));
        tick();
        chk("wr2", 128'({write_en, write_addr, write_data}), 128'({1'b1, 15'd2, 5'd5}));
        tick();
        chk("wr3", 128'({write_en, write_addr, write_data}), 128'({1'b1, 15'd3, 5'd6}));
        tick();
        chk("wr_end", 128'({write_en, busy, frame_done}), 128'(0));
        ppl_valid = 0;
        tick();

        // Fill FIFO while busy: ninth edit refused
        frame_req = 1;
        tick();
        frame_req = 0;
        for (int j = 0; j < 9; j++) begin
            edit_valid = 1; edit_addr = 15'(10 + j); edit_data = 5'(j);
            tick();
            if (j == 6) chk("ready_at7", 128'(edit_ready), 128'(1));
            if (j >= 7) chk("ready_full", 128'(edit_ready), 128'(0));
        end
        edit_valid = 0;
        nv = 0;
        for (int i = 0; i < 2000 && nv < NPIX; i++) begin
            ppl_valid = (i % 8 != 7);
            if (ppl_valid) nv++;
            tick();
        end
        ppl_valid = 0;
        chk("done2", 128'({frame_done, busy, timeout_err}), 128'(3'b100));

        // Drain with overlapping push+pop
        nwr = 0;
        for (int i = 0; i < 30; i++) begin
            edit_valid = (i >= 2 && i < 6);
            edit_addr  = 15'(16'h100 + i);
            edit_data  = 5'(i);
            tick();
            if (write_en) nwr++;
            if (i >= 2 && i < 6) chk("ready_pushpop", 128'(edit_ready), 128'(1));
        end
        edit_valid = 0;
        chk("drain_count", 128'(nwr), 128'(12));

        // Frame request wins over pending edit; then watchdog expiry
        edit_valid = 1; edit_addr = 15'h40; edit_data = 5'd7;
        tick();
        edit_valid = 0; frame_req = 1;
        tick();
        frame_req = 0;
        chk("frame_wins", 128'({write_en, busy}), 128'(2'b01));
        found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            tick();
            if (timeout_err) found = 1;
        end
        chk("timeout_seen", 128'({found, busy, frame_done}), 128'(3'b100));
        tick();
        chk("drain_after_to", 128'({write_en, write_addr, write_data}), 128'({1'b1, 15'h40, 5'd7}));
        frame_req = 1;
        tick();
        frame_req = 0;
        chk("terr_cleared", 128'(timeout_err), 128'(0));
        edit_valid = 1; edit_addr = 15'h77; edit_data = 5'd3;
        tick();
        edit_valid = 0;

        // Short watchdog instance: expiry after exactly TO_WD render cycles
        w_frame_req = 1;
        tick();
        w_frame_req = 0;
        for (k = 1; k <= 103; k++) begin
            w_edit_valid = (k == 1); w_edit_addr = 15'h55; w_edit_data = 5'd9;
            tick();
            if (k == 1) chk("wd_start", 128'(w_ppl_start), 128'(1));
            if (k == 101) chk("wd_before", 128'({w_timeout_err, w_busy}), 128'(2'b01));
            if (k == 102) chk("wd_expire", 128'({w_timeout_err, w_busy, w_frame_done}), 128'(3'b100));
            if (k == 103) chk("wd_drain", 128'({w_write_en, w_write_addr, w_write_data}), 128'({1'b1, 15'h55, 5'd9}));
        end
        w_edit_valid = 0;
        w_frame_req = 1;
        tick();
        w_frame_req = 0;
        chk("wd_clear", 128'({w_timeout_err, w_busy}), 128'(2'b01));
        tick(); tick();

        // Async reset mid-render drops state and queued edits
        rst_n = 0;
        #1;
        chk("arst_main", 128'({busy, ppl_start, write_en, frame_done, overrun, timeout_err,
                               p_pos_x, p_angle_x, write_addr, edit_ready}), 128'(1));
        chk("arst_wd", 128'({w_busy, w_ppl_start, w_write_en, w_timeout_err, w_p_pos_x, w_edit_ready}), 128'(1));
        tick();
        rst_n = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (write_en) seen = 1;
        end
        chk("edits_lost", 128'({seen, busy}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/render_sched.md
Name: render_sched

Overview:
Frame-level scheduler for the ray-cast render datapath (ppl → map → align), in the PPL clock domain.
- On each frame request it latches the player pose atomically and pulses a start to the ppl pipeline.
- It counts valid pixels to detect frame completion and enforces a watchdog.
- Block-edit writes to the map write port are buffered in a small FIFO and applied only while no frame is rendering, so a frame never sees a half-edited world.

Parameters:
H_DISP, 480, horizontal render resolution in pixels
V_DISP, 272, vertical render resolution in pixels
FIFO_DEPTH, 8, edit FIFO entries (power of two, ≥2)
TIMEOUT, 2000000, maximum RENDER cycles before abort

Ports:
clk  in  1  PPL clock
rst_n  in  1  asynchronous active-low reset
frame_req  in  1  one-cycle pulse requesting a new frame (already synchronised into clk)
in_pos_x / in_pos_y / in_pos_z  in  17 each  live player position, fixed-point <<7
in_angle_x / in_angle_y  in  20 each  live player view angles
ppl_valid  in  1  pipeline pixel-valid strobe (ppl valid output)
edit_valid  in  1  host block-edit request
edit_addr  in  15  block address of edit
edit_data  in  5  new block id
edit_ready  out  1  FIFO can accept an edit
p_pos_x / p_pos_y / p_pos_z  out  17 each  latched pose to ppl
p_angle_x / p_angle_y  out  20 each  latched angles to ppl
ppl_start  out  1  one-cycle start pulse to ppl
write_en  out  1  map write strobe
write_addr  out  15  map write address
write_data  out  5  map write data
busy  out  1  high in LATCH, START and RENDER
frame_done  out  1  one-cycle pulse at normal frame completion
overrun  out  1  one-cycle pulse when frame_req is dropped
timeout_err  out  1  sticky watchdog flag, cleared by next accepted frame_req

Behaviour:
- Reset: FSM=IDLE; all outputs 0, except edit_ready=1; FIFO emptied; counters 0.
- States: IDLE, LATCH, START, RENDER.
- IDLE
  - frame_req=1 → LATCH; no FIFO write issued in that cycle; clear timeout_err.
  - Otherwise, if FIFO non-empty, pop one entry per cycle and drive write_en=1 with its addr/data in that same registered cycle.
- LATCH: register all five pose inputs into the p_* outputs → START. p_* outputs change only here.
- START: ppl_start=1 for exactly one cycle; clear pix_cnt and wd_cnt → RENDER.
- RENDER
  - pix_cnt (20 bit) increments on each ppl_valid.
  - When pix_cnt reaches H_DISP*V_DISP−1 and ppl_valid=1: frame_done=1 next cycle → IDLE.
  - wd_cnt increments every cycle; on reaching TIMEOUT: timeout_err←1 → IDLE, with no frame_done.
- frame_req outside IDLE: dropped; overrun pulses one cycle later; FSM unaffected.
- FIFO behaviour:
  - Push when edit_valid & edit_ready; edit_ready = !full, registered view of the count.
  - Push and pop in the same cycle are both legal; count is unchanged.
  - When full, edit_ready=0 and no push occurs even if a pop happens that cycle; ready rises the following cycle.
  - Pushes are accepted in every state; pops occur only in IDLE.
  - Write order equals push order.
- Latencies:
  - frame_req (IDLE) to ppl_start: 2 cycles.
  - Last pixel to frame_done: 1 cycle.
  - FIFO push to write_en: ≥2 cycles when IDLE.
- Extra ppl_valid strobes after frame end, while in IDLE: ignored.
- Async reset mid-RENDER or mid-drain: immediate return to reset state; queued edits are lost.

Decomposition:
- Package render_pkg holds:
  - state encoding (2-bit enum);
  - POS_W=17, ANG_W=20, BADDR_W=15, BID_W=5, PIX_W=20;
  - function clog2.
- Sub-module edit_fifo: synchronous FIFO with push/pop/full/empty, WIDTH=20, depth FIFO_DEPTH.
- render_sched contains the FSM, counters and pose registers only.

Test Plan:
1. H_DISP=32, V_DISP=24. Reset, pulse frame_req with pos_x=0x5500, angle_x=30.
   → ppl_start 2 cycles later; p_pos_x=0x5500.
   → Feed 768 ppl_valid: frame_done exactly one cycle after the 768th; busy falls the same cycle.
2. Change in_pos_x during RENDER.
   → p_pos_x holds 0x5500 until the next LATCH.
3. Push 3 edits (addr 1,2,3 / data 4,5,6) during RENDER.
   → write_en stays 0 until frame_done.
   → Then 3 consecutive write_en cycles, in order 1/4, 2/5, 3/6.
4. Push 9 edits back-to-back with FIFO_DEPTH=8 while busy.
   → edit_ready=0 after the 8th; the 9th is not accepted.
   → Simultaneous push+pop in IDLE keeps count constant.
5. frame_req during RENDER.
   → overrun pulse 1 cycle later; no second ppl_start.
   → frame_req coinciding with a non-empty FIFO in IDLE: frame wins, no write that cycle.
6. TIMEOUT=100, no ppl_valid.
   → timeout_err=1 at cycle 100 of RENDER; FSM returns to IDLE; FIFO drains.
   → Next frame_req clears timeout_err.
   → Assert rst_n low mid-RENDER: all outputs 0, edit_ready=1.
